// File: rtl/tl_pkg.sv
// tl_pkg: TileLink-UL opcodes and the D-channel beat carried by the response queue
package tl_pkg;
  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [9:0]  source;
    logic        denied;
    logic [31:0] data;
  } tl_d_beat_t;
endpackage

// File: rtl/tl_rsp_fifo.sv
// tl_rsp_fifo: synchronous FIFO of D beats with registered head and occupancy count
module tl_rsp_fifo
  import tl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  tl_d_beat_t    push_data,
  input  logic          pop,
  output tl_d_beat_t    head,
  output logic [CW-1:0] count
);
  tl_d_beat_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (int'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (int'(rd_ptr) == DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clock)
    if (reset_n) assert (int'(count) <= DEPTH);
  assign head = mem[rd_ptr];
endmodule

// File: rtl/tl_ul_mem_responder.sv
// tl_ul_mem_responder: TileLink-UL slave backed by a word-addressed SRAM with queued D responses
module tl_ul_mem_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          RSP_DEPTH = 4,
  parameter logic [2:0]  SINK_ID   = 3'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_bits_opcode,
  input  logic [2:0]  a_bits_param,
  input  logic [3:0]  a_bits_size,
  input  logic [9:0]  a_bits_source,
  input  logic [31:0] a_bits_address,
  input  logic [3:0]  a_bits_mask,
  input  logic [31:0] a_bits_data,
  input  logic        a_bits_corrupt,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_bits_opcode,
  output logic [1:0]  d_bits_param,
  output logic [3:0]  d_bits_size,
  output logic [9:0]  d_bits_source,
  output logic [2:0]  d_bits_sink,
  output logic        d_bits_denied,
  output logic [31:0] d_bits_data,
  output logic        d_bits_corrupt
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] offset, rd_data;
  logic [AW-1:0] idx;
  logic [CW-1:0] q_count;
  logic rst_sync, s1_valid, s1_rd, a_fire, is_get, is_put, legal, unused;
  tl_d_beat_t s1_beat, push_beat, head, out;
  assign unused = ^{a_bits_param, a_bits_corrupt};
  assign offset = a_bits_address - BASE_ADDR;
  assign idx = offset[AW+1:2];
  assign is_get = a_bits_opcode == TL_GET;
  assign is_put = a_bits_opcode == TL_PUT_FULL || a_bits_opcode == TL_PUT_PARTIAL;
  assign legal = (is_get || is_put) && a_bits_size <= 4'd2 && a_bits_address[1:0] == 2'b00 &&
                 a_bits_address >= BASE_ADDR && offset < 32'(4 * MEM_WORDS);
  // Credit counts the beat still in s1 so the queue can never overflow.
  assign a_ready = rst_sync && (int'(q_count) + int'(s1_valid) < RSP_DEPTH);
  assign a_fire = a_valid && a_ready;
  always_ff @(posedge clock) begin
    if (a_fire && legal && is_put)
      for (int b = 0; b < 4; b++)
        if (a_bits_mask[b]) mem[idx][8*b +: 8] <= a_bits_data[8*b +: 8];
    if (a_fire && legal && is_get) rd_data <= mem[idx];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rst_sync <= 1'b0;
      s1_valid <= 1'b0;
      s1_rd    <= 1'b0;
      s1_beat  <= '0;
    end else begin
      rst_sync <= 1'b1;
      s1_valid <= a_fire;
      s1_rd    <= a_fire && legal && is_get;
      s1_beat  <= '{opcode: is_get ? TL_ACK_DATA : TL_ACK, size: a_bits_size,
                    source: a_bits_source, denied: !legal, data: '0};
    end
  always_comb begin
    push_beat = s1_beat;
    push_beat.data = s1_rd ? rd_data : '0;
  end
  tl_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clock(clock), .reset_n(reset_n), .push(s1_valid), .push_data(push_beat),
    .pop(d_valid && d_ready), .head(head), .count(q_count)
  );
  assign d_valid = q_count != '0;
  assign out = d_valid ? head : '0;
  assign d_bits_opcode = out.opcode;
  assign d_bits_param = 2'd0;
  assign d_bits_size = out.size;
  assign d_bits_source = out.source;
  assign d_bits_sink = d_valid ? SINK_ID : 3'd0;
  assign d_bits_denied = out.denied;
  assign d_bits_data = out.data;
  assign d_bits_corrupt = out.denied && out.opcode == TL_ACK_DATA;
endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// tb_tl_ul_mem_responder: randomized scoreboard bench for the TL-UL memory responder
module tb_tl_ul_mem_responder;
  logic clock = 0, reset_n = 0, a_valid = 0, a_ready, d_valid, d_ready = 0;
  logic [2:0] a_bits_opcode = 0, a_bits_param = 0, d_bits_opcode, d_bits_sink;
  logic [3:0] a_bits_size = 0, a_bits_mask = 0, d_bits_size;
  logic [9:0] a_bits_source = 0, d_bits_source;
  logic [31:0] a_bits_address = 0, a_bits_data = 0, d_bits_data;
  logic a_bits_corrupt = 0, d_bits_denied, d_bits_corrupt;
  logic [1:0] d_bits_param;
  int tests = 0, fails = 0, cyc = 0;
  bit rand_ready = 0;

  typedef struct {
    logic [2:0] opcode; logic [3:0] size; logic [9:0] source;
    logic denied; logic corrupt; logic [31:0] data; bit known; int at;
  } beat_t;
  beat_t exp_q[$], obs_q[$];
  logic [31:0] mdl [int];

  tl_ul_mem_responder dut (
    .clock(clock), .reset_n(reset_n), .a_valid(a_valid), .a_ready(a_ready),
    .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param), .a_bits_size(a_bits_size),
    .a_bits_source(a_bits_source), .a_bits_address(a_bits_address), .a_bits_mask(a_bits_mask),
    .a_bits_data(a_bits_data), .a_bits_corrupt(a_bits_corrupt), .d_valid(d_valid),
    .d_ready(d_ready), .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
    .d_bits_size(d_bits_size), .d_bits_source(d_bits_source), .d_bits_sink(d_bits_sink),
    .d_bits_denied(d_bits_denied), .d_bits_data(d_bits_data), .d_bits_corrupt(d_bits_corrupt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Reference: legality and memory effects straight from the protocol rules, applied in acceptance order.
  function automatic beat_t model(input logic [2:0] op, input logic [3:0] sz, input logic [9:0] src,
                                  input logic [31:0] addr, input logic [3:0] mk, input logic [31:0] dt);
    beat_t e;
    logic [31:0] t;
    bit get = op == 3'd4, put = op == 3'd0 || op == 3'd1;
    bit ok = (get || put) && sz <= 4'd2 && addr % 4 == 0 && addr >= 32'h8000_0000 && addr < 32'h8000_1000;
    int w = int'((addr - 32'h8000_0000) / 4);
    e = '{opcode: get ? 3'd1 : 3'd0, size: sz, source: src, denied: !ok, corrupt: !ok && get,
          data: 32'd0, known: 1, at: 0};
    if (ok && get) begin
      e.known = mdl.exists(w);
      if (e.known) e.data = mdl[w];
    end
    if (ok && put) begin
      if (mk == 4'hF) mdl[w] = dt;
      else if (mdl.exists(w)) begin
        t = mdl[w];
        for (int b = 0; b < 4; b++) if (mk[b]) t[8*b +: 8] = dt[8*b +: 8];
        mdl[w] = t;
      end
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset_n && d_valid && d_ready)
      obs_q.push_back('{opcode: d_bits_opcode, size: d_bits_size, source: d_bits_source,
                        denied: d_bits_denied, corrupt: d_bits_corrupt, data: d_bits_data, known: 1, at: cyc});
    if (reset_n && a_valid && a_ready)
      exp_q.push_back(model(a_bits_opcode, a_bits_size, a_bits_source, a_bits_address, a_bits_mask, a_bits_data));
  end

  task automatic send(input logic [2:0] op, input logic [3:0] sz, input logic [9:0] src,
                      input logic [31:0] addr, input logic [3:0] mk, input logic [31:0] dt);
    int n = 0;
    logic fired = 0;
    {a_bits_opcode, a_bits_size, a_bits_source, a_bits_address, a_bits_mask, a_bits_data} = {op, sz, src, addr, mk, dt};
    a_valid = 1;
    while (!fired && n < 100) begin
      @(negedge clock);
      fired = a_ready;
      @(posedge clock);
      #1;
      n++;
      if (rand_ready) d_ready = $urandom_range(0, 3) != 0;
    end
    a_valid = 0;
    tests++;
    if (!fired) begin fails++; $display("FAIL send_accept src=%0d got not accepted, need accepted", src); end
  endtask

  task automatic check_rsps(input string name, output logic [31:0] last);
    int n = 0;
    beat_t e, o;
    last = 'x;
    d_ready = 1;
    while (obs_q.size() < exp_q.size() && n < 300) begin @(posedge clock); n++; end
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_count got %0d beats, need %0d", name, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      last = o.data;
      tests++;
      if ({o.opcode, o.size, o.source, o.denied, o.corrupt} !== {e.opcode, e.size, e.source, e.denied, e.corrupt} ||
          (e.known && o.data !== e.data)) begin
        fails++;
        $display("FAIL %s_beat got op=%0d sz=%0d src=%0d den=%0d cor=%0d data=%h, need op=%0d sz=%0d src=%0d den=%0d cor=%0d data=%h",
                 name, o.opcode, o.size, o.source, o.denied, o.corrupt, o.data,
                 e.opcode, e.size, e.source, e.denied, e.corrupt, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++;
    if (a_ready !== 0 || d_valid !== 0) begin fails++; $display("FAIL reset_hs got a_ready=%b d_valid=%b, need 0 0", a_ready, d_valid); end
    tests++;
    if ({d_bits_opcode, d_bits_param, d_bits_size, d_bits_source, d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt} !== '0) begin
      fails++; $display("FAIL reset_dbits got src=%h data=%h, need all zero", d_bits_source, d_bits_data);
    end
    reset_n = 1;
    #1;
    tests++;
    if (a_ready !== 0) begin fails++; $display("FAIL reset_release got a_ready=%b, need 0", a_ready); end
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (a_ready !== 1) begin fails++; $display("FAIL reset_ready got a_ready=%b, need 1", a_ready); end
  endtask

  task automatic test_write_read();
    logic [31:0] last;
    d_ready = 1;
    send(3'd0, 4'd2, 10'd5, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
    tests++;
    if (d_valid !== 0) begin fails++; $display("FAIL latency_early got d_valid=%b, need 0", d_valid); end
    @(posedge clock);
    #1;
    tests++;
    if (d_valid !== 1 || d_bits_source !== 10'd5 || d_bits_opcode !== 3'd0) begin
      fails++; $display("FAIL latency_ack got v=%b src=%0d op=%0d, need 1 5 0", d_valid, d_bits_source, d_bits_opcode);
    end
    check_rsps("put_full", last);
    send(3'd4, 4'd2, 10'd6, 32'h8000_0010, 4'hF, 32'h0);
    check_rsps("get", last);
    tests++;
    if (last !== 32'hDEAD_BEEF) begin fails++; $display("FAIL get_data got %h, need deadbeef", last); end
  endtask

  task automatic test_partial();
    logic [31:0] last;
    send(3'd1, 4'd2, 10'd7, 32'h8000_0010, 4'h2, 32'h0000_1200);
    send(3'd4, 4'd2, 10'd8, 32'h8000_0010, 4'hF, 32'h0);
    check_rsps("partial", last);
    tests++;
    if (last !== 32'hDEAD_12EF) begin fails++; $display("FAIL partial_data got %h, need dead12ef", last); end
  endtask

  task automatic test_denied();
    logic [31:0] last;
    send(3'd0, 4'd2, 10'd20, 32'h8000_0000, 4'hF, 32'h1234_5678);
    send(3'd4, 4'd2, 10'd21, 32'h7FFF_FFFC, 4'hF, 32'h0);
    send(3'd4, 4'd3, 10'd22, 32'h8000_0010, 4'hF, 32'h0);
    send(3'd0, 4'd2, 10'd23, 32'h8000_1000, 4'hF, 32'hFFFF_FFFF);
    send(3'd2, 4'd2, 10'd24, 32'h8000_0000, 4'hF, 32'hFFFF_FFFF);
    send(3'd0, 4'd2, 10'd25, 32'h8000_0002, 4'hF, 32'hFFFF_FFFF);
    send(3'd4, 4'd2, 10'd26, 32'h8000_0000, 4'hF, 32'h0);
    check_rsps("denied", last);
    tests++;
    if (last !== 32'h1234_5678) begin fails++; $display("FAIL denied_nowrite got %h, need 12345678", last); end
  endtask

  task automatic test_backpressure();
    logic [31:0] last;
    logic [41:0] held = '0;
    int acc = 0, n = 0;
    logic [9:0] src = 10'd40;
    d_ready = 0;
    {a_bits_opcode, a_bits_size, a_bits_address} = {3'd4, 4'd2, 32'h8000_0010};
    a_valid = 1;
    for (int c = 0; c < 10; c++) begin
      a_bits_source = src;
      @(negedge clock);
      if (a_ready) begin acc++; src++; end
      if (c == 5) held = {d_bits_source, d_bits_data};
      if (c == 9) begin
        tests++;
        if (d_valid !== 1 || {d_bits_source, d_bits_data} !== held || d_bits_source !== 10'd40) begin
          fails++; $display("FAIL bp_stable got v=%b src=%0d, need 1 40 held", d_valid, d_bits_source);
        end
        tests++;
        if (a_ready !== 0) begin fails++; $display("FAIL bp_ready got a_ready=%b, need 0", a_ready); end
      end
      @(posedge clock);
      #1;
    end
    tests++;
    if (acc != 4) begin fails++; $display("FAIL bp_accepted got %0d, need 4", acc); end
    d_ready = 1;
    while (acc < 6 && n < 50) begin
      a_bits_source = src;
      @(negedge clock);
      if (a_ready) begin acc++; src++; end
      @(posedge clock);
      #1;
      n++;
    end
    a_valid = 0;
    tests++;
    if (acc != 6) begin fails++; $display("FAIL bp_drain got %0d accepted, need 6", acc); end
    check_rsps("backpressure", last);
  endtask

  task automatic test_stream();
    logic [31:0] last;
    int stalls = 0, n = 0;
    for (int i = 0; i < 24; i++) send(3'd0, 4'd2, 10'(60 + i), 32'h8000_0100 + 32'(4 * i), 4'hF, $urandom);
    check_rsps("prefill", last);
    d_ready = 1;
    a_valid = 1;
    for (int i = 0; i < 20; i++) begin
      {a_bits_opcode, a_bits_size, a_bits_source, a_bits_address} = {3'd4, 4'd2, 10'(100 + i), 32'h8000_0100 + 32'(4 * i)};
      @(negedge clock);
      if (!a_ready) stalls++;
      @(posedge clock);
      #1;
    end
    a_valid = 0;
    tests++;
    if (stalls != 0) begin fails++; $display("FAIL stream_stalls got %0d, need 0", stalls); end
    while (obs_q.size() < 20 && n < 100) begin @(posedge clock); n++; end
    #1;
    tests++;
    if (obs_q.size() < 20 || obs_q[19].at - obs_q[0].at != 19) begin
      fails++; $display("FAIL stream_rate got %0d beats, need 20 on consecutive cycles", obs_q.size());
    end
    check_rsps("stream", last);
  endtask

  task automatic test_random_mix();
    logic [31:0] last, addr;
    logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd2};
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      addr = 32'h8000_0100 + 32'(4 * $urandom_range(0, 23));
      if ($urandom_range(0, 7) == 0) addr = addr + 32'h1000;
      if ($urandom_range(0, 9) == 0) addr = addr + 32'd1;
      send(ops[$urandom_range(0, 4)], ($urandom_range(0, 9) == 0) ? 4'd3 : 4'($urandom_range(0, 2)),
           10'(200 + i), addr, 4'($urandom_range(0, 15)), $urandom);
    end
    rand_ready = 0;
    check_rsps("random", last);
  endtask

  task automatic test_midreset();
    logic [31:0] last;
    d_ready = 1;
    a_valid = 1;
    for (int i = 0; i < 6; i++) begin
      {a_bits_opcode, a_bits_size, a_bits_source, a_bits_address} = {3'd4, 4'd2, 10'(300 + i), 32'h8000_0100 + 32'(4 * i)};
      @(posedge clock);
      #1;
    end
    reset_n = 0;
    a_valid = 0;
    #1;
    tests++;
    if (d_valid !== 0 || a_ready !== 0) begin fails++; $display("FAIL midreset_now got v=%b rdy=%b, need 0 0", d_valid, a_ready); end
    obs_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    repeat (12) @(posedge clock);
    #1;
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL midreset_stale got %0d beats, need 0", obs_q.size()); end
    send(3'd4, 4'd2, 10'd400, 32'h8000_0100, 4'hF, 32'h0);
    check_rsps("after_reset", last);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_denied();
    test_backpressure();
    test_stream();
    test_random_mix();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
